pulse_period_meter: RTL and testbench
=====================================

Name: pulse_period_meter

Overview:
Consumes a periodic single-cycle tick, such as the output of the team's tick/prescaler counter. It measures the number of clk cycles between successive ticks and reports last, minimum and maximum period plus a measured-period count. A sticky timeout flags a tick source that has stalled. It sits on the receiving side of any tick line, for clock-divider checking and debug readout.

Parameters:
WIDTH, 32, width of the cycle counter and of all period/count outputs.
TIMEOUT, 1000, cycles without a tick before timeout is raised; 0 disables timeout.

Ports:
clk  input  1  clock; all logic on posedge.
reset  input  1  synchronous, active-low reset.
enable  input  1  measurement enable; low forces IDLE.
pulse_in  input  1  tick input; every cycle sampled high is one event (no edge detect, so a permanently high input means period 1).
period  output  WIDTH  last measured period in clk cycles.
period_valid  output  1  one-cycle strobe when period is updated.
min_period  output  WIDTH  smallest period since reset.
max_period  output  WIDTH  largest period since reset.
event_count  output  WIDTH  number of measured periods since reset, saturating.
timeout  output  1  sticky stall flag.

Behaviour:
- Reset (reset==0 at posedge): state IDLE, internal cnt=0, period=0, period_valid=0, min_period=all ones, max_period=0, event_count=0, timeout=0. Reset wins over all other inputs, including mid-measurement.
- Event: pulse_in==1 and enable==1 at posedge.
- States:
  - IDLE: entered when enable==0.
    - cnt=0, period_valid=0; period/min/max/count/timeout held.
    - enable==1 moves to ARMED; an event in that same cycle moves directly to MEASURE.
  - ARMED: waiting for the first reference event.
    - An event moves to MEASURE with cnt=0 and produces no period_valid.
  - MEASURE: counting.
    - Let k = cnt+1 = cycles since the last event.
    - On an event:
      - period=k and period_valid=1 for exactly this cycle.
      - min_period=min(min_period,k), max_period=max(max_period,k), event_count+=1 (saturating at all ones).
      - cnt=0; stay in MEASURE.
    - No event and TIMEOUT!=0 and k==TIMEOUT: timeout=1, cnt=0, go to ARMED. No period is reported.
    - Otherwise: cnt=cnt+1, saturating at all ones. A saturated period is reported as all ones.
- Latency: period/min/max/count are updated at the same posedge that samples the event and are visible the cycle after.
- Ticks one cycle apart give period 1. A continuously high pulse_in gives period_valid high every cycle with period=1.
- Simultaneous event and timeout threshold (k==TIMEOUT): the event wins, period=TIMEOUT is reported and timeout is not set. Maximum reportable period when timeout is enabled is TIMEOUT.
- timeout clears only on reset. Events after a timeout re-arm and measure normally while timeout stays 1.
- enable falling in MEASURE or ARMED: next state IDLE and the partial measurement is discarded. Re-enable requires a fresh reference event.
- min/max are compared with unsigned arithmetic, WIDTH bits. TIMEOUT must fit in WIDTH bits; parameter check in simulation only.

Decomposition:
- Shared package: state encoding typedef (IDLE, ARMED, MEASURE) and a saturating-increment helper function; both are reused by other tick-domain blocks.
- Natural sub-module: sat_counter (WIDTH-bit saturating incrementer with synchronous clear). Instanced for cnt and for event_count.
- FSM and min/max logic stay in pulse_period_meter.

Test Plan:
- Tick source emitting one-cycle pulses every 10 cycles, enable=1 -> first pulse produces no strobe. Each later pulse gives period_valid=1 and period=10; min_period=max_period=10; event_count increments by 1 per strobe.
- pulse_in held high continuously -> from the second high cycle, period_valid=1 every cycle, period=1, min_period=1.
- TIMEOUT=50, ticks every 20 cycles, then stopped -> timeout=1 at exactly 50 cycles after the last tick. The next tick gives no strobe; the one after, 20 cycles later, gives period=20 with timeout still 1.
- TIMEOUT=50, second tick exactly 50 cycles after the first -> period=50, period_valid=1, timeout stays 0.
- Tick gaps of 7, 3, then 12 -> min_period=3, max_period=12, event_count=3, period=12.
- Reset asserted mid-MEASURE (cnt=5) -> next cycle all outputs at reset values. enable dropped mid-MEASURE -> IDLE with outputs held; after re-enable the first tick gives no strobe.

Source files
------------

// File: rtl/pulse_period_meter_pkg.sv
// Shared tick-domain definitions: FSM state encoding and a saturating increment.
package pulse_period_meter_pkg;

   localparam int unsigned SAT_MAX_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_MEASURE = 2'd2
   } tick_state_e;

   // Increment v, clamping at the all-ones value of a w-bit field (w <= SAT_MAX_W).
   function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                    input int unsigned         w);
      logic [SAT_MAX_W-1:0] top;
      top = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - w);
      return (v >= top) ? top : v + SAT_MAX_W'(1);
   endfunction

endpackage

// File: rtl/pulse_period_meter_sat_counter.sv
// WIDTH-bit saturating up-counter with synchronous clear.
module pulse_period_meter_sat_counter
   import pulse_period_meter_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = WIDTH'(sat_inc(SAT_MAX_W'(cnt_q), WIDTH));
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures clk cycles between successive tick events; reports last/min/max period,
// a saturating period count and a sticky stall timeout.
module pulse_period_meter
   import pulse_period_meter_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             pulse_in,
   output logic [WIDTH-1:0] period,
   output logic             period_valid,
   output logic [WIDTH-1:0] min_period,
   output logic [WIDTH-1:0] max_period,
   output logic [WIDTH-1:0] event_count,
   output logic             timeout
);

   localparam bit               TO_EN = (TIMEOUT != 0);
   localparam logic [WIDTH-1:0] TO_K  = WIDTH'(TIMEOUT);

   if ((WIDTH == 0) || (WIDTH > SAT_MAX_W)) begin : g_bad_width
      $error("pulse_period_meter: WIDTH must be 1..%0d", SAT_MAX_W);
   end
   if (WIDTH < 32) begin : g_to_chk
      if (TIMEOUT > ((32'd1 << WIDTH) - 32'd1)) begin : g_bad_to
         $error("pulse_period_meter: TIMEOUT does not fit in WIDTH bits");
      end
   end

   tick_state_e      state_q;
   logic [WIDTH-1:0] period_q;
   logic             valid_q;
   logic [WIDTH-1:0] min_q;
   logic [WIDTH-1:0] max_q;
   logic             timeout_q;

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] k_d;
   logic             in_meas;
   logic             meas_ev;
   logic             to_hit;
   logic             cnt_inc;

   // k is the period that an event in this cycle would report.
   assign k_d     = WIDTH'(sat_inc(SAT_MAX_W'(cnt), WIDTH));
   assign in_meas = (state_q == ST_MEASURE);
   assign meas_ev = in_meas & enable & pulse_in;
   assign to_hit  = TO_EN && (k_d == TO_K);
   assign cnt_inc = in_meas & enable & ~pulse_in & ~to_hit;

   pulse_period_meter_sat_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr_i (~cnt_inc),
      .inc_i (cnt_inc),
      .cnt_o (cnt)
   );

   pulse_period_meter_sat_counter #(.WIDTH(WIDTH)) u_event_count (
      .clk   (clk),
      .reset (reset),
      .clr_i (1'b0),
      .inc_i (meas_ev),
      .cnt_o (event_count)
   );

   // Measurement FSM with registered period/min/max/timeout outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         period_q  <= '0;
         valid_q   <= 1'b0;
         min_q     <= '1;
         max_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (!enable) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_q <= pulse_in ? ST_MEASURE : ST_ARMED;
               end
               ST_ARMED: begin
                  if (pulse_in) begin
                     state_q <= ST_MEASURE;
                  end
               end
               ST_MEASURE: begin
                  // An event on the threshold cycle wins over the timeout.
                  if (pulse_in) begin
                     period_q <= k_d;
                     valid_q  <= 1'b1;
                     if (k_d < min_q) begin
                        min_q <= k_d;
                     end
                     if (k_d > max_q) begin
                        max_q <= k_d;
                     end
                  end else if (to_hit) begin
                     timeout_q <= 1'b1;
                     state_q   <= ST_ARMED;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign period       = period_q;
   assign period_valid = valid_q;
   assign min_period   = min_q;
   assign max_period   = max_q;
   assign timeout      = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Checks three differently configured meters against a time-stamp based reference model.
module tb_pulse_period_meter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic pin = 1'b0;
   bit   chk_on = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   logic [31:0] a_per, a_min, a_max, a_cnt;
   logic        a_val, a_to;
   logic [7:0]  b_per, b_min, b_max, b_cnt;
   logic        b_val, b_to;
   logic [3:0]  c_per, c_min, c_max, c_cnt;
   logic        c_val, c_to;

   pulse_period_meter #(.WIDTH(32), .TIMEOUT(1000)) dut_a (
      .clk(clk), .reset(rst_n), .enable(en), .pulse_in(pin),
      .period(a_per), .period_valid(a_val), .min_period(a_min),
      .max_period(a_max), .event_count(a_cnt), .timeout(a_to));

   pulse_period_meter #(.WIDTH(8), .TIMEOUT(50)) dut_b (
      .clk(clk), .reset(rst_n), .enable(en), .pulse_in(pin),
      .period(b_per), .period_valid(b_val), .min_period(b_min),
      .max_period(b_max), .event_count(b_cnt), .timeout(b_to));

   pulse_period_meter #(.WIDTH(4), .TIMEOUT(0)) dut_c (
      .clk(clk), .reset(rst_n), .enable(en), .pulse_in(pin),
      .period(c_per), .period_valid(c_val), .min_period(c_min),
      .max_period(c_max), .event_count(c_cnt), .timeout(c_to));

   logic [31:0] d_per[3], d_min[3], d_max[3], d_cnt[3];
   logic        d_val[3], d_to[3];

   assign d_per[0] = a_per;       assign d_per[1] = 32'(b_per); assign d_per[2] = 32'(c_per);
   assign d_min[0] = a_min;       assign d_min[1] = 32'(b_min); assign d_min[2] = 32'(c_min);
   assign d_max[0] = a_max;       assign d_max[1] = 32'(b_max); assign d_max[2] = 32'(c_max);
   assign d_cnt[0] = a_cnt;       assign d_cnt[1] = 32'(b_cnt); assign d_cnt[2] = 32'(c_cnt);
   assign d_val[0] = a_val;       assign d_val[1] = b_val;      assign d_val[2] = c_val;
   assign d_to[0]  = a_to;        assign d_to[1]  = b_to;       assign d_to[2]  = c_to;

   function automatic int cw(input int i);
      case (i)
         0:       return 32;
         1:       return 8;
         default: return 4;
      endcase
   endfunction

   function automatic int cto(input int i);
      case (i)
         0:       return 1000;
         1:       return 50;
         default: return 0;
      endcase
   endfunction

   // Reference model: remembers the time stamp of the last event and derives
   // each period as a time difference, clamped to the output width.
   typedef struct packed {
      logic        have_ref;
      logic [63:0] ref_t;
      logic [31:0] per;
      logic [31:0] mn;
      logic [31:0] mx;
      logic [31:0] cnt;
      logic        val;
      logic        to;
   } mst_t;

   mst_t        m[3];
   logic [63:0] now = 64'd0;

   function automatic mst_t mstep(input mst_t s, input int w, input int to,
                                  input logic r, input logic e, input logic p,
                                  input logic [63:0] t);
      mst_t        n;
      logic [63:0] mask;
      logic [63:0] k;
      mask  = (64'd1 << w) - 64'd1;
      n     = s;
      n.val = 1'b0;
      if (!r) begin
         n.have_ref = 1'b0;
         n.ref_t    = 64'd0;
         n.per      = 32'd0;
         n.mn       = 32'(mask);
         n.mx       = 32'd0;
         n.cnt      = 32'd0;
         n.to       = 1'b0;
      end else if (!e) begin
         n.have_ref = 1'b0;
      end else if (p) begin
         if (s.have_ref) begin
            k = t - s.ref_t;
            if (k > mask) k = mask;
            n.per = 32'(k);
            n.val = 1'b1;
            if (32'(k) < s.mn) n.mn = 32'(k);
            if (32'(k) > s.mx) n.mx = 32'(k);
            if (64'(s.cnt) < mask) n.cnt = s.cnt + 32'd1;
         end
         n.have_ref = 1'b1;
         n.ref_t    = t;
      end else if (s.have_ref && (to != 0) && ((t - s.ref_t) == 64'(to))) begin
         n.to       = 1'b1;
         n.have_ref = 1'b0;
      end
      return n;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         m[i] <= mstep(m[i], cw(i), cto(i), rst_n, en, pin, now);
      end
      now <= now + 64'd1;
   end

   task automatic chk(input string nm, input int i, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of all three meters against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         for (int i = 0; i < 3; i++) begin
            chk("period", i, d_per[i], m[i].per);
            chk("period_valid", i, 32'(d_val[i]), 32'(m[i].val));
            chk("min_period", i, d_min[i], m[i].mn);
            chk("max_period", i, d_max[i], m[i].mx);
            chk("event_count", i, d_cnt[i], m[i].cnt);
            chk("timeout", i, 32'(d_to[i]), 32'(m[i].to));
         end
      end
   end

   task automatic step(input logic r, input logic e, input logic p);
      rst_n = r;
      en    = e;
      pin   = p;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int gap);
      repeat (gap - 1) step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
   endtask

   int dens;

   initial begin
      do_reset();
      chk_on = 1'b1;
      chk("lit_reset_min", 0, a_min, 32'hFFFF_FFFF);
      chk("lit_reset_cnt", 0, a_cnt, 32'd0);

      // Regular ticks every 10 cycles.
      step(1'b1, 1'b1, 1'b1);
      chk("lit_first_no_strobe", 0, 32'(a_val), 32'd0);
      repeat (4) pulse(10);
      chk("lit_p10_period", 0, a_per, 32'd10);
      chk("lit_p10_valid", 0, 32'(a_val), 32'd1);
      chk("lit_p10_min", 0, a_min, 32'd10);
      chk("lit_p10_max", 0, a_max, 32'd10);
      chk("lit_p10_cnt", 0, a_cnt, 32'd4);

      // Continuously high tick input.
      do_reset();
      repeat (20) step(1'b1, 1'b1, 1'b1);
      chk("lit_hi_period", 0, a_per, 32'd1);
      chk("lit_hi_min", 0, a_min, 32'd1);
      chk("lit_hi_cnt", 0, a_cnt, 32'd19);
      chk("lit_hi_cnt_sat", 2, 32'(c_cnt), 32'd15);

      // Stall detection on the TIMEOUT=50 meter.
      do_reset();
      step(1'b1, 1'b1, 1'b1);
      pulse(20);
      pulse(20);
      repeat (49) step(1'b1, 1'b1, 1'b0);
      chk("lit_to_before", 1, 32'(b_to), 32'd0);
      step(1'b1, 1'b1, 1'b0);
      chk("lit_to_at50", 1, 32'(b_to), 32'd1);
      pulse(5);
      chk("lit_to_rearm_no_strobe", 1, 32'(b_val), 32'd0);
      pulse(20);
      chk("lit_to_after_period", 1, 32'(b_per), 32'd20);
      chk("lit_to_after_valid", 1, 32'(b_val), 32'd1);
      chk("lit_to_sticky", 1, 32'(b_to), 32'd1);

      // Event exactly on the timeout threshold wins.
      do_reset();
      step(1'b1, 1'b1, 1'b1);
      pulse(50);
      chk("lit_edge_period", 1, 32'(b_per), 32'd50);
      chk("lit_edge_valid", 1, 32'(b_val), 32'd1);
      chk("lit_edge_no_to", 1, 32'(b_to), 32'd0);

      // Mixed gaps.
      do_reset();
      step(1'b1, 1'b1, 1'b1);
      pulse(7);
      pulse(3);
      pulse(12);
      chk("lit_mix_min", 0, a_min, 32'd3);
      chk("lit_mix_max", 0, a_max, 32'd12);
      chk("lit_mix_cnt", 0, a_cnt, 32'd3);
      chk("lit_mix_period", 0, a_per, 32'd12);

      // Reset in the middle of a measurement.
      do_reset();
      step(1'b1, 1'b1, 1'b1);
      pulse(10);
      repeat (5) step(1'b1, 1'b1, 0);
      step(1'b0, 1'b1, 1'b1);
      chk("lit_midrst_period", 0, a_per, 32'd0);
      chk("lit_midrst_cnt", 0, a_cnt, 32'd0);
      chk("lit_midrst_min", 0, a_min, 32'hFFFF_FFFF);

      // Enable dropped mid-measurement, then re-enabled.
      step(1'b1, 1'b1, 1'b1);
      pulse(10);
      repeat (3) step(1'b1, 1'b1, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b1);
      chk("lit_dis_period_held", 0, a_per, 32'd10);
      chk("lit_dis_cnt_held", 0, a_cnt, 32'd1);
      step(1'b1, 1'b1, 1'b0);
      pulse(4);
      chk("lit_reen_no_strobe", 0, 32'(a_val), 32'd0);
      pulse(10);
      chk("lit_reen_period", 0, a_per, 32'd10);
      chk("lit_reen_cnt", 0, a_cnt, 32'd2);

      // Period saturation on the 4-bit meter.
      do_reset();
      step(1'b1, 1'b1, 1'b1);
      pulse(21);
      chk("lit_sat_period", 2, 32'(c_per), 32'd15);
      chk("lit_sat_valid", 2, 32'(c_val), 32'd1);
      chk("lit_nosat_period", 1, 32'(b_per), 32'd21);

      // Randomized traffic with varying tick density.
      dens = 30;
      for (int n = 0; n < 3000; n++) begin
         if ((n % 400) == 0) begin
            case ($urandom_range(0, 3))
               0:       dens = 1;
               1:       dens = 5;
               2:       dens = 40;
               default: dens = 90;
            endcase
         end
         step(logic'($urandom_range(0, 299) != 0),
              logic'($urandom_range(0, 99) >= 3),
              logic'($urandom_range(0, 99) < dens));
      end

      step(1'b1, 1'b1, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
